// File: rtl/bf16_to_sint.sv
// bf16_to_sint: two-stage BF16 to signed fixed-point converter with
// round-toward-zero, saturation and ovf/nan/inexact status flags.
module bf16_to_sint #(
   parameter int OUT_W  = 23,
   parameter int FRAC_W = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      bf16_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic             out_nan,
   output logic             out_inexact
);

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } cls_e;

   localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [9:0] K_OFS = 10'(FRAC_W - 127);
   localparam logic signed [9:0] K_SAT = 10'(OUT_W - 1);

   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_sign_q, s1_sign_d;
   cls_e                    s1_cls_q, s1_cls_d;
   logic signed [9:0]       s1_k_q, s1_k_d;
   logic [6:0]              s1_m_q, s1_m_d;

   logic                    out_valid_q, out_valid_d;
   logic [OUT_W-1:0]        out_data_q, out_data_d;
   logic                    out_ovf_q, out_ovf_d;
   logic                    out_nan_q, out_nan_d;
   logic                    out_inexact_q, out_inexact_d;

   logic                    s2_load;
   logic                    s1_load;

   logic [7:0]              in_exp;
   logic [6:0]              in_man;

   logic [7:0]              sig;
   logic [4:0]              shl;
   logic [2:0]              shr;
   logic [31:0]             mag;
   logic                    lost;

   logic                    pos_sat;
   logic                    neg_sat;
   logic                    neg_min;
   logic [OUT_W-1:0]        res_data;
   logic                    res_ovf;
   logic                    res_nan;
   logic                    res_inexact;

   // handshake: each stage refills whenever its content moves on
   always_comb begin
      s2_load  = !out_valid_q || out_ready;
      s1_load  = !s1_valid_q || s2_load;
      in_ready = rst_n && s1_load;
   end

   always_comb begin
      in_exp     = bf16_in[14:7];
      in_man     = bf16_in[6:0];
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_cls_d   = s1_cls_q;
      s1_k_d     = s1_k_q;
      s1_m_d     = s1_m_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_sign_d = bf16_in[15];
            s1_m_d    = in_man;
            s1_k_d    = $signed({2'b00, in_exp}) + K_OFS;
            unique case (1'b1)
               in_exp == 8'd0: begin
                  s1_cls_d = CLS_ZERO;
               end
               in_exp == 8'hFF && in_man == 7'd0: begin
                  s1_cls_d = CLS_INF;
               end
               in_exp == 8'hFF && in_man != 7'd0: begin
                  s1_cls_d = CLS_NAN;
               end
               default: begin
                  s1_cls_d = CLS_NORM;
               end
            endcase
         end
      end
   end

   // magnitude of the normal significand, before saturation
   always_comb begin
      sig  = {1'b1, s1_m_q};
      shl  = 5'(s1_k_q - 10'sd7);
      shr  = 3'(10'sd7 - s1_k_q);
      mag  = 32'd0;
      lost = 1'b0;
      unique case (1'b1)
         s1_k_q < 0: begin
            lost = 1'b1;
         end
         s1_k_q >= 0 && s1_k_q < 10'sd7: begin
            mag  = {24'd0, sig >> shr};
            lost = |(sig & ~(8'hFF << shr));
         end
         default: begin
            mag = {24'd0, sig} << shl;
         end
      endcase
   end

   always_comb begin
      pos_sat     = !s1_sign_q && (s1_k_q >= K_SAT);
      neg_sat     = s1_sign_q && ((s1_k_q > K_SAT) ||
                    (s1_k_q == K_SAT && s1_m_q != 7'd0));
      neg_min     = s1_sign_q && s1_k_q == K_SAT && s1_m_q == 7'd0;
      res_data    = '0;
      res_ovf     = 1'b0;
      res_nan     = 1'b0;
      res_inexact = 1'b0;
      unique case (s1_cls_q)
         CLS_ZERO: begin
            res_data = '0;
         end
         CLS_NAN: begin
            res_nan = 1'b1;
         end
         CLS_INF: begin
            res_data = s1_sign_q ? MIN_V : MAX_V;
            res_ovf  = 1'b1;
         end
         default: begin
            unique case (1'b1)
               pos_sat: begin
                  res_data = MAX_V;
                  res_ovf  = 1'b1;
               end
               neg_sat: begin
                  res_data = MIN_V;
                  res_ovf  = 1'b1;
               end
               neg_min: begin
                  res_data = MIN_V;
               end
               default: begin
                  res_data    = s1_sign_q ? -mag[OUT_W-1:0]
                                          : mag[OUT_W-1:0];
                  res_inexact = lost;
               end
            endcase
         end
      endcase
   end

   // output registers hold while stalled so data stays stable
   always_comb begin
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_ovf_d     = out_ovf_q;
      out_nan_d     = out_nan_q;
      out_inexact_d = out_inexact_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d    = res_data;
            out_ovf_d     = res_ovf;
            out_nan_d     = res_nan;
            out_inexact_d = res_inexact;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_cls_q      <= CLS_ZERO;
         s1_k_q        <= '0;
         s1_m_q        <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_ovf_q     <= 1'b0;
         out_nan_q     <= 1'b0;
         out_inexact_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_sign_q     <= s1_sign_d;
         s1_cls_q      <= s1_cls_d;
         s1_k_q        <= s1_k_d;
         s1_m_q        <= s1_m_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_ovf_q     <= out_ovf_d;
         out_nan_q     <= out_nan_d;
         out_inexact_q <= out_inexact_d;
      end
   end

   always_comb begin
      out_valid   = out_valid_q;
      out_data    = out_data_q;
      out_ovf     = out_ovf_q;
      out_nan     = out_nan_q;
      out_inexact = out_inexact_q;
   end

endmodule
